bk_mouse_port: RTL

//  Downstream of ps2_mouse: converts decoded PS/2 motion packets into the BK joystick/mouse

---
 rtl/bk_mouse_port.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bk_mouse_port.sv
// BK joystick/mouse port word: accumulates PS/2 motion per axis, issues one read-to-clear
// direction bit per THRESH counts, and mirrors the button state.
module bk_mouse_port #(
  parameter int ACC_W        = 12,
  parameter int THRESH       = 4,
  parameter int IDLE_TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pkt_valid,
  input  logic [8:0]  pkt_dx,
  input  logic [8:0]  pkt_dy,
  input  logic        pkt_left,
  input  logic        pkt_right,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rd,
  output logic [15:0] port_dout,
  output logic        enabled
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PEND_POS = 2'd1;
  localparam logic [1:0] ST_PEND_NEG = 2'd2;

  // Two guard bits so acc + delta - THRESH never overflows before saturation.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -SUM_W'(2 ** (ACC_W - 1));
  localparam logic signed [SUM_W-1:0] THR_S   = SUM_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_A   = ACC_W'(THRESH);

  localparam bit IDLE_EN = (IDLE_TIMEOUT > 0);
  localparam int IDLE_W  = IDLE_EN ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_TOP  = IDLE_W'(IDLE_EN ? IDLE_TIMEOUT : 0);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_EN ? IDLE_TIMEOUT - 1 : 0);

  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [1:0]              st_x_q, st_x_d, st_y_q, st_y_d;
  logic                    btn_left_q, btn_left_d, btn_right_q, btn_right_d;
  logic                    en_q, en_d;
  logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic                    idle_hit;

  logic unused_wr_bits;
  assign unused_wr_bits = ^{cpu_wr_data[7:4], cpu_wr_data[2:0]};

  // One axis: threshold step is judged on the registered accumulator, while the
  // incoming delta and the step adjustment land in the same sum before saturating.
  function automatic logic [ACC_W+1:0] step_axis(
    input logic [1:0]              st_q,
    input logic signed [ACC_W-1:0] acc_q,
    input logic signed [8:0]       delta,
    input logic                    do_add,
    input logic                    rd
  );
    logic [1:0]              st;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] dlt;
    st  = st_q;
    sum = SUM_W'(acc_q);
    dlt = SUM_W'(delta);
    if (do_add) sum = sum + dlt;
    case (st_q)
      ST_IDLE: begin
        if (acc_q >= THR_A) begin
          st  = ST_PEND_POS;
          sum = sum - THR_S;
        end else if (acc_q <= -THR_A) begin
          st  = ST_PEND_NEG;
          sum = sum + THR_S;
        end
      end
      ST_PEND_POS, ST_PEND_NEG: if (rd) st = ST_IDLE;
      default: st = ST_IDLE;
    endcase
    if (sum > ACC_MAX)      sum = ACC_MAX;
    else if (sum < ACC_MIN) sum = ACC_MIN;
    return {st, sum[ACC_W-1:0]};
  endfunction

  assign idle_hit = IDLE_EN && !pkt_valid && (idle_cnt_q == IDLE_LAST);

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    st_x_d      = st_x_q;
    st_y_d      = st_y_q;
    btn_left_d  = btn_left_q;
    btn_right_d = btn_right_q;
    en_d        = en_q;
    idle_cnt_d  = idle_cnt_q;

    if (pkt_valid) begin
      btn_left_d  = pkt_left;
      btn_right_d = pkt_right;
      idle_cnt_d  = '0;
    end else if (idle_cnt_q != IDLE_TOP) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    if (cpu_wr) begin
      en_d = cpu_wr_data[3];
      if (!cpu_wr_data[3]) begin
        acc_x_d = '0;
        acc_y_d = '0;
        st_x_d  = ST_IDLE;
        st_y_d  = ST_IDLE;
      end
    end else if (!en_q) begin
      st_x_d = ST_IDLE;
      st_y_d = ST_IDLE;
    end else begin
      {st_x_d, acc_x_d} = step_axis(st_x_q, acc_x_q, pkt_dx, pkt_valid, cpu_rd);
      {st_y_d, acc_y_d} = step_axis(st_y_q, acc_y_q, pkt_dy, pkt_valid, cpu_rd);
    end

    // Timeout drops residual motion only; a pending direction bit stays readable.
    if (idle_hit) begin
      acc_x_d = '0;
      acc_y_d = '0;
    end
  end

  // NOTE: the reset here is synchronous (sampled only on clk) to match the bus domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      st_x_q      <= ST_IDLE;
      st_y_q      <= ST_IDLE;
      btn_left_q  <= 1'b0;
      btn_right_q <= 1'b0;
      en_q        <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      st_x_q      <= st_x_d;
      st_y_q      <= st_y_d;
      btn_left_q  <= btn_left_d;
      btn_right_q <= btn_right_d;
      en_q        <= en_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign port_dout = {9'b0, btn_right_q, btn_left_q, 1'b0,
                      (st_x_q == ST_PEND_NEG), (st_y_q == ST_PEND_NEG),
                      (st_x_q == ST_PEND_POS), (st_y_q == ST_PEND_POS)};
  assign enabled   = en_q;

endmodule
